sos_coef_ctrl: RTL and testbench
================================

// Module: sos_coef_ctrl
// PURPOSE
//  Configuration controller for a cascade of NUM_SECTIONS opti_sos biquad sections.
//  Host writes coefficients into a shadow bank. cfg_commit then requests a swap.
//  The block stalls upstream samples, drains the cascade pipeline and swaps shadow->active atomically,
//  so no in-flight sample ever sees mixed coefficient sets.
//  Sits between the sample source and the first opti_sos; drives b0..a2 of every section.
// PARAMETERS
//  NUM_SECTIONS  4          number of cascaded SOS sections served
//  MAX_INFLIGHT  64         in-flight counter capacity (>= total cascade latency in samples)
//  COEF_UNITY    24'h200000 reset value of every b0 (other coefficients reset to 0)
// PORTS
//  clk          in   1              single clock, all logic on rising edge
//  rst          in   1              asynchronous, active-high reset
//  cfg_wr_en    in   1              shadow write strobe
//  cfg_addr     in   ADDR_W         {section, idx[2:0]}; idx 0..4 = b0,b1,b2,a1,a2
//  cfg_wdata    in   24             signed coefficient
//  cfg_commit   in   1              pulse: request shadow->active swap
//  cfg_busy     out  1              high in DRAIN/SWAP
//  cfg_err      out  1              1-cycle pulse: bad address, write while busy, or counter fault
//  commit_done  out  1              1-cycle pulse on the cycle active bank updates
//  s_valid      in   1              upstream sample valid
//  s_data       in   24             upstream sample
//  s_ready      out  1              upstream may transfer when s_valid&s_ready
//  dp_valid_in  out  1              to first section data_valid_in
//  dp_data_in   out  24             to first section data_in
//  dp_valid_out in   1              data_valid_out of last section
//  coef_b0..a2  out  24*NUM_SECTIONS flattened active coefficients, section 0 in LSBs
//  cfg_rd_en    in   1              [COEF_READBACK_EN only] read strobe
//  cfg_rdata    out  24             [COEF_READBACK_EN only] readback data
//  cfg_rvalid   out  1              [COEF_READBACK_EN only] readback valid
// BEHAVIOUR
//  Reset: state=RUN, inflight=0, cfg_busy=0, cfg_err=0, commit_done=0.
//   Shadow and active banks: b0=COEF_UNITY, all else 0. cfg_rdata=0, cfg_rvalid=0.
//  FSM RUN: s_ready=1.
//   cfg_commit -> DRAIN next cycle.
//   A sample transferred on the commit cycle is counted and drained.
//  FSM DRAIN: s_ready=0, cfg_busy=1. Go to SWAP when inflight==0, evaluated each cycle.
//   Go to SWAP the next cycle if inflight is already 0.
//  FSM SWAP: single cycle. Active<=shadow, commit_done=1 (registered, same edge as the active update).
//   Return to RUN.
//  Pass-through is combinational, 0 latency:
//   dp_valid_in = s_valid & s_ready; dp_data_in = s_data.
//  inflight: +1 on dp_valid_in, -1 on dp_valid_out, unchanged when both occur.
//   Increment at MAX_INFLIGHT or decrement at 0: hold value and pulse cfg_err.
//  Writes: accepted only in RUN. idx>4 or section>=NUM_SECTIONS -> dropped, cfg_err.
//   cfg_wr_en in DRAIN/SWAP -> dropped, cfg_err.
//   cfg_wr_en together with cfg_commit in RUN: the write lands in shadow and is part of the commit.
//  cfg_commit outside RUN is ignored; there is no error and it is not queued.
//  Active bank changes only in SWAP; coef_* are register outputs, stable otherwise.
//  Reset asserted mid-DRAIN: immediate return to reset state; pending commit is discarded.
// CONFIGURATION
//  `COEF_READBACK_EN defined:
//   cfg_rd_en in any state reads the active bank at cfg_addr.
//   cfg_rdata/cfg_rvalid are registered, 1-cycle latency. A bad address returns 0 with cfg_err.
//  Not defined: ports cfg_rd_en/cfg_rdata/cfg_rvalid and all read logic are absent.
// STRUCTURE
//  Package sos_ctrl_pkg:
//   COEF_W=24; coefficient index constants IDX_B0..IDX_A2; state enum {RUN,DRAIN,SWAP};
//   ADDR_W function = clog2(NUM_SECTIONS)+3.
//  Sub-module sos_coef_bank: shadow+active register arrays, write decode, swap, flattened outputs.
//   The FSM and inflight counter stay in the top.
// TESTING
//  Reset -> all coef_b0 = 24'h200000, others 0; s_ready=1; inflight=0.
//  Write sec1 b1=24'h100000, commit with inflight=0 -> SWAP in 2 cycles; commit_done pulse;
//   coef_b1[47:24]=24'h100000.
//  Feed 10 samples, commit while 10 in flight -> s_ready=0 until 10th dp_valid_out;
//   coef unchanged until then.
//  Write addr {sec0,idx 6} and write during DRAIN -> cfg_err pulse each; shadow unchanged.
//  dp_valid_in and dp_valid_out same cycle at inflight=5 -> stays 5; spurious dp_valid_out at 0 -> cfg_err.
//  Assert rst during DRAIN -> state RUN, banks back to reset values, no commit_done.

Source files
------------

// File: rtl/sos_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sos_ctrl_pkg
// Shared definitions for the SOS coefficient controller slice:
//   COEF_W        coefficient / sample width
//   NUM_COEF      coefficients per biquad section (b0,b1,b2,a1,a2)
//   IDX_B0..A2    coefficient index field values inside cfg_addr[2:0]
//   state_t       controller FSM states
//   addr_w()      host address width for a given section count
// -----------------------------------------------------------------------------
package sos_ctrl_pkg;

  localparam int COEF_W   = 24;
  localparam int NUM_COEF = 5;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  // Address is {section, idx[2:0]}.
  function automatic int addr_w(input int num_sections);
    return $clog2(num_sections) + 3;
  endfunction

endpackage

// File: rtl/sos_coef_bank.sv
// -----------------------------------------------------------------------------
// sos_coef_bank
// Shadow and active coefficient registers for NUM_SECTIONS biquad sections.
// The host writes land in the shadow bank; a one-cycle swap copies the whole
// shadow bank into the active bank at once so the datapath never sees a
// partially updated set.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en                    qualified shadow write (address already checked)
//   wr_sec, wr_idx, wr_data  target section, coefficient index, value
//   swap                     copy shadow -> active on this edge
//   coef_b0..coef_a2         active coefficients, section 0 in the LSBs
// -----------------------------------------------------------------------------
module sos_coef_bank
  import sos_ctrl_pkg::*;
#(
  parameter int                NUM_SECTIONS = 4,
  parameter logic [COEF_W-1:0] COEF_UNITY   = 24'h200000,
  localparam int               SEC_W        = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [SEC_W-1:0]               wr_sec,
  input  logic [2:0]                     wr_idx,
  input  logic [COEF_W-1:0]              wr_data,
  input  logic                           swap,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b0,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b1,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b2,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_a1,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_a2
);

  // All active coefficients packed as {section, coef} words.
  logic [COEF_W*NUM_COEF*NUM_SECTIONS-1:0] active_flat;

  for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
    for (genvar ci = 0; ci < NUM_COEF; ci++) begin : g_coef
      // b0 resets to unity so the cascade starts out as a pass-through.
      localparam logic [COEF_W-1:0] RST_VAL = (ci == int'(IDX_B0)) ? COEF_UNITY : '0;

      logic [COEF_W-1:0] shadow_reg;
      logic [COEF_W-1:0] active_reg;
      logic              hit;

      assign hit = wr_en && (wr_sec == SEC_W'(gi)) && (wr_idx == 3'(ci));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg <= RST_VAL;
          active_reg <= RST_VAL;
        end else begin
          if (hit) begin
            shadow_reg <= wr_data;
          end
          if (swap) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign active_flat[(gi*NUM_COEF+ci)*COEF_W +: COEF_W] = active_reg;
    end

    assign coef_b0[gi*COEF_W +: COEF_W] = active_flat[(gi*NUM_COEF+int'(IDX_B0))*COEF_W +: COEF_W];
    assign coef_b1[gi*COEF_W +: COEF_W] = active_flat[(gi*NUM_COEF+int'(IDX_B1))*COEF_W +: COEF_W];
    assign coef_b2[gi*COEF_W +: COEF_W] = active_flat[(gi*NUM_COEF+int'(IDX_B2))*COEF_W +: COEF_W];
    assign coef_a1[gi*COEF_W +: COEF_W] = active_flat[(gi*NUM_COEF+int'(IDX_A1))*COEF_W +: COEF_W];
    assign coef_a2[gi*COEF_W +: COEF_W] = active_flat[(gi*NUM_COEF+int'(IDX_A2))*COEF_W +: COEF_W];
  end

endmodule

// File: rtl/sos_coef_ctrl.sv
// -----------------------------------------------------------------------------
// sos_coef_ctrl
// Coefficient configuration controller for a cascade of NUM_SECTIONS biquads.
// Sits between the sample source and the first section. On cfg_commit it stops
// accepting samples, waits until every in-flight sample has left the last
// section, then swaps shadow -> active coefficients in one cycle.
// Optional feature macro: COEF_READBACK_EN (adds cfg_rd_en/cfg_rdata/cfg_rvalid
// readback of the active bank).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cfg_wr_en/cfg_addr/cfg_wdata   shadow write, addr = {section, idx[2:0]}
//   cfg_commit                     request a shadow -> active swap
//   cfg_busy                       high while draining or swapping
//   cfg_err                        1-cycle pulse: bad write or counter fault
//   commit_done                    1-cycle pulse as the active bank updates
//   s_valid/s_data/s_ready         upstream sample handshake
//   dp_valid_in/dp_data_in         to the first section
//   dp_valid_out                   valid from the last section
//   coef_b0..coef_a2               active coefficients, section 0 in LSBs
//   cfg_rd_en/cfg_rdata/cfg_rvalid readback (COEF_READBACK_EN only)
// -----------------------------------------------------------------------------
module sos_coef_ctrl
  import sos_ctrl_pkg::*;
#(
  parameter int                NUM_SECTIONS = 4,
  parameter int                MAX_INFLIGHT = 64,
  parameter logic [COEF_W-1:0] COEF_UNITY   = 24'h200000,
  localparam int               ADDR_W       = addr_w(NUM_SECTIONS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_wr_en,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [COEF_W-1:0]              cfg_wdata,
  input  logic                           cfg_commit,
  output logic                           cfg_busy,
  output logic                           cfg_err,
  output logic                           commit_done,
  input  logic                           s_valid,
  input  logic [COEF_W-1:0]              s_data,
  output logic                           s_ready,
  output logic                           dp_valid_in,
  output logic [COEF_W-1:0]              dp_data_in,
  input  logic                           dp_valid_out,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b0,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b1,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_b2,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_a1,
  output logic [COEF_W*NUM_SECTIONS-1:0] coef_a2
`ifdef COEF_READBACK_EN
  ,
  input  logic                           cfg_rd_en,
  output logic [COEF_W-1:0]              cfg_rdata,
  output logic                           cfg_rvalid
`endif
);

  localparam int SEC_W = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  inflight_reg, inflight_next;
  logic              cfg_err_reg, cfg_err_next;
  logic              commit_done_reg;
  logic              cnt_fault;
  logic              rd_err;

  // ---------------------------------------------------------------------------
  // Address decode (shared by writes and readback)
  // ---------------------------------------------------------------------------
  logic [2:0]        addr_idx;
  logic [ADDR_W-1:0] addr_sec_full;
  logic [SEC_W-1:0]  addr_sec;
  logic              addr_ok;

  assign addr_idx      = cfg_addr[2:0];
  assign addr_sec_full = cfg_addr >> 3;
  assign addr_sec      = addr_sec_full[SEC_W-1:0];
  assign addr_ok       = (addr_idx <= IDX_A2) && (addr_sec_full < ADDR_W'(NUM_SECTIONS));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    cfg_busy   = 1'b0;
    unique case (state_reg)
      RUN: begin
        s_ready = 1'b1;
        if (cfg_commit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        cfg_busy = 1'b1;
        // Uses the registered count, so the last dp_valid_out edge is followed
        // by one more DRAIN cycle before SWAP.
        if (inflight_reg == '0) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        cfg_busy   = 1'b1;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Zero-latency pass-through; stalling is purely via s_ready.
  assign dp_valid_in = s_valid & s_ready;
  assign dp_data_in  = s_data;

  // ---------------------------------------------------------------------------
  // In-flight sample counter; saturates at both ends and flags the fault.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_next = inflight_reg;
    cnt_fault     = 1'b0;
    if (dp_valid_in && !dp_valid_out) begin
      if (inflight_reg == CNT_W'(MAX_INFLIGHT)) begin
        cnt_fault = 1'b1;
      end else begin
        inflight_next = inflight_reg + 1'b1;
      end
    end else if (!dp_valid_in && dp_valid_out) begin
      if (inflight_reg == '0) begin
        cnt_fault = 1'b1;
      end else begin
        inflight_next = inflight_reg - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host writes: only accepted in RUN. A write on the commit cycle is still in
  // RUN, so it reaches the shadow bank before the later SWAP copies it.
  // ---------------------------------------------------------------------------
  logic wr_accept;
  logic wr_err;
  logic swap;

  assign wr_accept = cfg_wr_en && (state_reg == RUN) && addr_ok;
  assign wr_err    = cfg_wr_en && ((state_reg != RUN) || !addr_ok);
  assign swap      = (state_reg == SWAP);

  assign cfg_err_next = wr_err | cnt_fault | rd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg    <= '0;
      cfg_err_reg     <= 1'b0;
      commit_done_reg <= 1'b0;
    end else begin
      inflight_reg    <= inflight_next;
      cfg_err_reg     <= cfg_err_next;
      commit_done_reg <= swap;
    end
  end

  assign cfg_err     = cfg_err_reg;
  assign commit_done = commit_done_reg;

  sos_coef_bank #(
    .NUM_SECTIONS (NUM_SECTIONS),
    .COEF_UNITY   (COEF_UNITY)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_sec  (addr_sec),
    .wr_idx  (addr_idx),
    .wr_data (cfg_wdata),
    .swap    (swap),
    .coef_b0 (coef_b0),
    .coef_b1 (coef_b1),
    .coef_b2 (coef_b2),
    .coef_a1 (coef_a1),
    .coef_a2 (coef_a2)
  );

  // ---------------------------------------------------------------------------
  // Optional readback of the active bank
  // ---------------------------------------------------------------------------
`ifdef COEF_READBACK_EN
  logic [COEF_W-1:0] rd_word;

  assign rd_err = cfg_rd_en && !addr_ok;

  always_comb begin
    rd_word = '0;
    if (addr_ok) begin
      unique case (addr_idx)
        IDX_B0:  rd_word = coef_b0[COEF_W*int'(addr_sec) +: COEF_W];
        IDX_B1:  rd_word = coef_b1[COEF_W*int'(addr_sec) +: COEF_W];
        IDX_B2:  rd_word = coef_b2[COEF_W*int'(addr_sec) +: COEF_W];
        IDX_A1:  rd_word = coef_a1[COEF_W*int'(addr_sec) +: COEF_W];
        IDX_A2:  rd_word = coef_a2[COEF_W*int'(addr_sec) +: COEF_W];
        default: rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
    end else begin
      cfg_rvalid <= cfg_rd_en;
      if (cfg_rd_en) begin
        cfg_rdata <= rd_word;
      end
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_sos_coef_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sos_coef_ctrl
// Scenario tasks drive the controller; expected coefficient banks come from a
// plain array model of the shadow/active sets, and expected drain timing from
// the number of samples the bench itself has pushed into the cascade.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sos_coef_ctrl;

  localparam int          NS    = 4;
  localparam int          AW    = 5;
  localparam int          CW    = 24;
  localparam int          MAXF  = 64;
  localparam logic [23:0] UNITY = 24'h200000;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_wr_en, cfg_commit, s_valid, dp_valid_out;
  logic [AW-1:0]    cfg_addr;
  logic [CW-1:0]    cfg_wdata, s_data, dp_data_in;
  logic             cfg_busy, cfg_err, commit_done, s_ready, dp_valid_in;
  logic [CW*NS-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
`ifdef COEF_READBACK_EN
  logic             cfg_rd_en;
  logic [CW-1:0]    cfg_rdata;
  logic             cfg_rvalid;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: shadow and active coefficient sets.
  logic [23:0] sh_m  [NS][5];
  logic [23:0] act_m [NS][5];

  always #5 clk = ~clk;

  sos_coef_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_commit   (cfg_commit),
    .cfg_busy     (cfg_busy),
    .cfg_err      (cfg_err),
    .commit_done  (commit_done),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .dp_valid_in  (dp_valid_in),
    .dp_data_in   (dp_data_in),
    .dp_valid_out (dp_valid_out),
    .coef_b0      (coef_b0),
    .coef_b1      (coef_b1),
    .coef_b2      (coef_b2),
    .coef_a1      (coef_a1),
    .coef_a2      (coef_a2)
`ifdef COEF_READBACK_EN
    ,
    .cfg_rd_en    (cfg_rd_en),
    .cfg_rdata    (cfg_rdata),
    .cfg_rvalid   (cfg_rvalid)
`endif
  );

  function automatic logic [23:0] dut_coef(input int s, input int i);
    case (i)
      0:       return coef_b0[s*CW +: CW];
      1:       return coef_b1[s*CW +: CW];
      2:       return coef_b2[s*CW +: CW];
      3:       return coef_a1[s*CW +: CW];
      default: return coef_a2[s*CW +: CW];
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        sh_m[s][i]  = (i == 0) ? UNITY : 24'h0;
        act_m[s][i] = (i == 0) ? UNITY : 24'h0;
      end
  endtask

  task automatic model_commit();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++)
        act_m[s][i] = sh_m[s][i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cfg_wr_en    = 1'b0;
    cfg_commit   = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    dp_valid_out = 1'b0;
`ifdef COEF_READBACK_EN
    cfg_rd_en    = 1'b0;
`endif
  endtask

  // One accepted shadow write in RUN; the model follows it.
  task automatic host_write(input int s, input int i, input logic [23:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = AW'((s << 3) | i);
    cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
    sh_m[s][i] = d;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = 24'($urandom);
      tick();
    end
    s_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model_reset();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", cfg_busy); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", commit_done); end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_coef(s, i) !== act_m[s][i]) begin
          bad++; $display("FAIL reset_coef s%0d i%0d got=%h exp=%h", s, i, dut_coef(s, i), act_m[s][i]);
        end
      end
    $display("reset: checked banks and handshake");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_commit();
    logic [23:0] r;
    r = 24'($urandom);
    host_write(1, 1, 24'h100000);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL wr_ok_err got=%b exp=0", cfg_err); end
    host_write(2, 4, r);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL wc_drain_busy got=%b exp=1", cfg_busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL wc_drain_ready got=%b exp=0", s_ready); end
    total++; if (coef_b1[47:24] !== 24'h0) begin bad++; $display("FAIL wc_early_coef got=%h exp=000000", coef_b1[47:24]); end
    tick();
    total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL wc_swap_done got=%b exp=0", commit_done); end
    tick();
    model_commit();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL wc_done got=%b exp=1", commit_done); end
    total++; if (coef_b1[47:24] !== 24'h100000) begin bad++; $display("FAIL wc_b1_sec1 got=%h exp=100000", coef_b1[47:24]); end
    total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL wc_busy_after got=%b exp=0", cfg_busy); end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_coef(s, i) !== act_m[s][i]) begin
          bad++; $display("FAIL wc_coef s%0d i%0d got=%h exp=%h", s, i, dut_coef(s, i), act_m[s][i]);
        end
      end
    tick();
    total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL wc_done_pulse got=%b exp=0", commit_done); end
    $display("write_commit: sec1 b1 and sec2 a2=%h committed", r);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drain();
    int s, i, gap;
    logic [23:0] d;
    s = $urandom_range(0, NS - 1);
    i = $urandom_range(0, 4);
    d = 24'($urandom);
    host_write(s, i, d);
    // Ten samples, the tenth transferred together with the commit.
    for (int k = 0; k < 10; k++) begin
      s_valid    = 1'b1;
      s_data     = 24'($urandom);
      cfg_commit = (k == 9);
      #1;
      total++; if (dp_valid_in !== 1'b1 || dp_data_in !== s_data) begin
        bad++; $display("FAIL pass_through got=%b/%h exp=1/%h", dp_valid_in, dp_data_in, s_data);
      end
      tick();
    end
    cfg_commit = 1'b0;
    s_data     = 24'($urandom);
    for (int k = 0; k < 10; k++) begin
      total++; if (s_ready !== 1'b0 || dp_valid_in !== 1'b0) begin
        bad++; $display("FAIL drain_stall k%0d got=%b/%b exp=0/0", k, s_ready, dp_valid_in);
      end
      total++; if (commit_done !== 1'b0 || cfg_busy !== 1'b1) begin
        bad++; $display("FAIL drain_state k%0d got=%b/%b exp=0/1", k, commit_done, cfg_busy);
      end
      total++; if (dut_coef(s, i) !== act_m[s][i]) begin
        bad++; $display("FAIL drain_coef k%0d got=%h exp=%h", k, dut_coef(s, i), act_m[s][i]);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      dp_valid_out = 1'b1;
      if (k == 9) s_valid = 1'b0;
      tick();
      dp_valid_out = 1'b0;
    end
    total++; if (cfg_busy !== 1'b1 || commit_done !== 1'b0) begin
      bad++; $display("FAIL drain_last got=%b/%b exp=1/0", cfg_busy, commit_done);
    end
    tick();
    total++; if (commit_done !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("FAIL drain_swap got=%b/%b exp=0/0", commit_done, s_ready);
    end
    tick();
    model_commit();
    total++; if (commit_done !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL drain_done got=%b/%b exp=1/1", commit_done, s_ready);
    end
    for (int ss = 0; ss < NS; ss++)
      for (int ii = 0; ii < 5; ii++) begin
        total++;
        if (dut_coef(ss, ii) !== act_m[ss][ii]) begin
          bad++; $display("FAIL drain_coef_after s%0d i%0d got=%h exp=%h", ss, ii, dut_coef(ss, ii), act_m[ss][ii]);
        end
      end
    tick();
    $display("drain: 10 samples, s%0d i%0d=%h", s, i, d);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_errors();
    int bad_idx [3] = '{6, 5, 7};
    for (int k = 0; k < 3; k++) begin
      cfg_wr_en = 1'b1;
      cfg_addr  = AW'(((k == 0 ? 0 : $urandom_range(0, NS - 1)) << 3) | bad_idx[k]);
      cfg_wdata = 24'($urandom);
      tick();
      cfg_wr_en = 1'b0;
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad_addr_err idx%0d got=%b exp=1", bad_idx[k], cfg_err); end
      tick();
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL bad_addr_pulse idx%0d got=%b exp=0", bad_idx[k], cfg_err); end
    end
    // One sample in flight so DRAIN lasts a while.
    s_valid    = 1'b1;
    s_data     = 24'($urandom);
    cfg_commit = 1'b1;
    tick();
    s_valid    = 1'b0;
    cfg_commit = 1'b0;
    // Write (and a second commit) during DRAIN: both dropped.
    cfg_wr_en  = 1'b1;
    cfg_addr   = AW'(($urandom_range(0, NS - 1) << 3) | $urandom_range(0, 4));
    cfg_wdata  = 24'($urandom);
    cfg_commit = 1'b1;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL busy_wr_err got=%b exp=1", cfg_err); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL busy_wr_pulse got=%b exp=0", cfg_err); end
    dp_valid_out = 1'b1;
    tick();
    dp_valid_out = 1'b0;
    tick();
    tick();
    model_commit();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL err_commit_done got=%b exp=1", commit_done); end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_coef(s, i) !== act_m[s][i]) begin
          bad++; $display("FAIL err_shadow s%0d i%0d got=%h exp=%h", s, i, dut_coef(s, i), act_m[s][i]);
        end
      end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (commit_done !== 1'b0 || cfg_busy !== 1'b0) begin
        bad++; $display("FAIL commit_not_queued c%0d got=%b/%b exp=0/0", k, commit_done, cfg_busy);
      end
    end
    $display("errors: bad idx and busy write dropped");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_counter();
    feed(5);
    // In and out on the same cycle: count stays at 5.
    s_valid      = 1'b1;
    dp_valid_out = 1'b1;
    tick();
    s_valid      = 1'b0;
    dp_valid_out = 1'b0;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL both_err got=%b exp=0", cfg_err); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dp_valid_out = 1'b1;
      tick();
      dp_valid_out = 1'b0;
      total++; if (cfg_busy !== 1'b1 || commit_done !== 1'b0) begin
        bad++; $display("FAIL cnt5_drain k%0d got=%b/%b exp=1/0", k, cfg_busy, commit_done);
      end
    end
    tick();
    tick();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL cnt5_done got=%b exp=1", commit_done); end
    tick();
    // Spurious output at zero.
    dp_valid_out = 1'b1;
    tick();
    dp_valid_out = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL underflow_err got=%b exp=1", cfg_err); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL underflow_pulse got=%b exp=0", cfg_err); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL underflow_hold got=%b exp=1", commit_done); end
    tick();
    // Fill to capacity, then one more.
    feed(MAXF);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", cfg_err); end
    feed(1);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%b exp=1", cfg_err); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    dp_valid_out = 1'b1;
    repeat (MAXF) tick();
    dp_valid_out = 1'b0;
    total++; if (cfg_err !== 1'b0 || cfg_busy !== 1'b1 || commit_done !== 1'b0) begin
      bad++; $display("FAIL overflow_drain got=%b/%b/%b exp=0/1/0", cfg_err, cfg_busy, commit_done);
    end
    tick();
    tick();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL overflow_hold got=%b exp=1", commit_done); end
    tick();
    $display("counter: simultaneous, underflow and overflow");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_drain();
    host_write($urandom_range(0, NS - 1), $urandom_range(0, 4), 24'($urandom));
    s_valid = 1'b1;
    s_data  = 24'($urandom);
    tick();
    tick();
    cfg_commit = 1'b1;
    tick();
    s_valid    = 1'b0;
    cfg_commit = 1'b0;
    total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL rmd_busy got=%b exp=1", cfg_busy); end
    rst = 1'b1;
    #1;
    model_reset();
    total++; if (cfg_busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL rmd_async got=%b/%b exp=0/1", cfg_busy, s_ready);
    end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_coef(s, i) !== act_m[s][i]) begin
          bad++; $display("FAIL rmd_coef s%0d i%0d got=%h exp=%h", s, i, dut_coef(s, i), act_m[s][i]);
        end
      end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (commit_done !== 1'b0 || cfg_busy !== 1'b0) begin
        bad++; $display("FAIL rmd_no_commit c%0d got=%b/%b exp=0/0", k, commit_done, cfg_busy);
      end
    end
    // Shadow was reset too, and the counter forgot the in-flight samples.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    model_commit();
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL rmd_commit got=%b exp=1", commit_done); end
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_coef(s, i) !== act_m[s][i]) begin
          bad++; $display("FAIL rmd_shadow s%0d i%0d got=%h exp=%h", s, i, dut_coef(s, i), act_m[s][i]);
        end
      end
    tick();
    $display("reset_mid_drain: pending commit discarded");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int nw, ns, gap, ws, wi;
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++)
        host_write($urandom_range(0, NS - 1), $urandom_range(0, 4), 24'($urandom));
      ns = $urandom_range(0, 6);
      if (ns > 1) feed(ns - 1);
      // Commit cycle carries a write and, if any, the last sample.
      ws = $urandom_range(0, NS - 1);
      wi = $urandom_range(0, 4);
      cfg_commit = 1'b1;
      cfg_wr_en  = 1'b1;
      cfg_addr   = AW'((ws << 3) | wi);
      cfg_wdata  = 24'($urandom);
      sh_m[ws][wi] = cfg_wdata;
      s_valid    = (ns > 0);
      s_data     = 24'($urandom);
      tick();
      cfg_commit = 1'b0;
      cfg_wr_en  = 1'b0;
      s_valid    = 1'b0;
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL b2b_err r%0d got=%b exp=0", r, cfg_err); end
      for (int k = 0; k < ns; k++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) tick();
        dp_valid_out = 1'b1;
        tick();
        dp_valid_out = 1'b0;
      end
      total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL b2b_early r%0d got=%b exp=0", r, commit_done); end
      tick();
      total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL b2b_swap r%0d got=%b exp=0", r, commit_done); end
      tick();
      model_commit();
      total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL b2b_done r%0d got=%b exp=1", r, commit_done); end
      for (int s = 0; s < NS; s++)
        for (int i = 0; i < 5; i++) begin
          total++;
          if (dut_coef(s, i) !== act_m[s][i]) begin
            bad++; $display("FAIL b2b_coef r%0d s%0d i%0d got=%h exp=%h", r, s, i, dut_coef(s, i), act_m[s][i]);
          end
        end
      $display("back_to_back r%0d: %0d writes, %0d samples", r, nw + 1, ns);
      tick();
    end
  endtask

`ifdef COEF_READBACK_EN
  task automatic test_readback();
    for (int k = 0; k < 6; k++) begin
      int s, i;
      s = $urandom_range(0, NS - 1);
      i = (k == 5) ? 6 : $urandom_range(0, 4);
      cfg_rd_en = 1'b1;
      cfg_addr  = AW'((s << 3) | i);
      tick();
      cfg_rd_en = 1'b0;
      total++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== ((i < 5) ? act_m[s][i] : 24'h0) || cfg_err !== (i >= 5)) begin
        bad++; $display("FAIL readback s%0d i%0d got=%b/%h/%b", s, i, cfg_rvalid, cfg_rdata, cfg_err);
      end
      tick();
    end
    $display("readback: active bank read");
  endtask
`endif

  initial begin
    test_reset();
    test_write_commit();
    test_drain();
    test_errors();
    test_counter();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef COEF_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
